// File: rtl/ball_pkg.sv
// Shared constants for the ball speed generator: level count, period table
// and the level-bus width derivation.
package ball_pkg;

  // Number of speed levels in the default table.
  localparam int NUM_LEVELS_DEF = 9;

  // Ball period per level in clk cycles, slowest (level 0) to fastest.
  localparam int unsigned BALL_PERIOD [NUM_LEVELS_DEF] =
    '{1000, 800, 600, 500, 400, 300, 200, 100, 50};

  // Width of a bus that can carry any level index; never narrower than 1.
  function automatic int lvl_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_level_enc.sv
// Priority encoder: the highest set switch sw[i] selects level i+1,
// no switch set selects level 0.
module sw_level_enc
  import ball_pkg::*;
#(
  parameter int NUM_LEVELS = NUM_LEVELS_DEF,
  parameter int LVL_W      = lvl_width(NUM_LEVELS)
) (
  input  logic [NUM_LEVELS-2:0] sw,
  output logic [LVL_W-1:0]      level
);

  // stage[k] is the encoded level considering only sw[k-1:0]; each stage
  // lets a higher switch override everything below it.
  logic [LVL_W-1:0] stage [NUM_LEVELS];

  assign stage[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEVELS - 1; gi++) begin : g_prio
      assign stage[gi+1] = sw[gi] ? LVL_W'(gi + 1) : stage[gi];
    end
  endgenerate

  assign level = stage[NUM_LEVELS-1];

endmodule

// File: rtl/ball_speed_gen.sv
// Ball speed generator: one period counter whose length follows the
// committed speed level. Level changes are only taken at the wrap so every
// period runs at full length, and tick / clk_ball come from that counter.
module ball_speed_gen
  import ball_pkg::*;
#(
  parameter int NUM_LEVELS = NUM_LEVELS_DEF,
  parameter int CNT_W      = 20,
  parameter int LVL_W      = lvl_width(NUM_LEVELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [NUM_LEVELS-2:0] sw,
  input  logic                  hit,
  input  logic                  serve,
  output logic                  tick,
  output logic                  clk_ball,
  output logic [LVL_W-1:0]      level,
  output logic                  at_max
);

  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(NUM_LEVELS - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic [LVL_W-1:0] auto_reg, auto_next;
  logic             tick_reg, tick_next;
  logic             clk_ball_reg, clk_ball_next;

  logic [LVL_W-1:0] enc_level;
  logic [LVL_W-1:0] req_level;
  logic [CNT_W-1:0] period_cur;
  logic [CNT_W-1:0] period_nxt;
  logic [CNT_W-1:0] period_tbl [NUM_LEVELS];

  // Period table sized to the level count; extra levels reuse the fastest.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEVELS; gi++) begin : g_tbl
      if (gi < NUM_LEVELS_DEF) begin : g_dflt
        assign period_tbl[gi] = CNT_W'(BALL_PERIOD[gi]);
      end else begin : g_pad
        assign period_tbl[gi] = CNT_W'(BALL_PERIOD[NUM_LEVELS_DEF-1]);
      end
    end
  endgenerate

  sw_level_enc #(
    .NUM_LEVELS (NUM_LEVELS),
    .LVL_W      (LVL_W)
  ) u_enc (
    .sw    (sw),
    .level (enc_level)
  );

  assign req_level  = mode ? auto_reg : enc_level;
  assign period_cur = period_tbl[level_reg];
  assign period_nxt = period_tbl[level_next];

  // Auto level: tracks the switches in manual mode; in auto mode serve
  // reloads from the switches (and beats hit), hit steps up to the maximum.
  always_comb begin
    auto_next = auto_reg;
    if (!mode || serve) begin
      auto_next = enc_level;
    end else if (hit && (auto_reg != MAX_LVL)) begin
      auto_next = auto_reg + LVL_W'(1);
    end
  end

  // Counter, wrap-time level commit and tick; everything freezes with en low.
  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    tick_next  = 1'b0;
    if (en) begin
      if (cnt_reg == period_cur - CNT_W'(1)) begin
        cnt_next   = '0;
        level_next = req_level;
        tick_next  = 1'b1;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  // clk_ball is high for the first floor(P/2) counts of each period; it is
  // computed from the upcoming count so it rises together with tick.
  always_comb begin
    clk_ball_next = clk_ball_reg;
    if (en) begin
      clk_ball_next = (cnt_next < (period_nxt >> 1));
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      level_reg    <= '0;
      auto_reg     <= '0;
      tick_reg     <= 1'b0;
      clk_ball_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      level_reg    <= level_next;
      auto_reg     <= auto_next;
      tick_reg     <= tick_next;
      clk_ball_reg <= clk_ball_next;
    end
  end

  assign tick     = tick_reg;
  assign clk_ball = clk_ball_reg;
  assign level    = level_reg;
  assign at_max   = (level_reg == MAX_LVL);

endmodule

// File: tb/tb_ball_speed_gen.sv
// Randomised scoreboard bench for ball_speed_gen. A cycle-level reference
// model of the period/level rules predicts every tick (cycle, level, clk_ball
// high time); a separate monitor matches each observed tick against it.
module tb_ball_speed_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic [7:0] sw;
  logic       hit;
  logic       serve;
  logic       tick;
  logic       clk_ball;
  logic [3:0] level;
  logic       at_max;

  ball_speed_gen dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .sw       (sw),
    .hit      (hit),
    .serve    (serve),
    .tick     (tick),
    .clk_ball (clk_ball),
    .level    (level),
    .at_max   (at_max)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int cyc;   // cycle index in which tick must be seen
    int lvl;   // level committed at that wrap
    int hc;    // clk_ball high cycles of the period just ended, -1 = skip
  } exp_t;

  int   per_tab [9] = '{1000, 800, 600, 500, 400, 300, 200, 100, 50};
  exp_t q [$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  int   m_elapsed = 0;
  int   m_lvl = 0;
  int   m_auto = 0;
  bit   m_clean = 0;
  bit   rst_prev = 1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int enc_of(input logic [7:0] s);
    int r = 0;
    for (int i = 0; i < 8; i++) if (s[i]) r = i + 1;
    return r;
  endfunction

  // One clock of the specification rules, using the inputs held this cycle.
  task automatic model_step();
    int   enc;
    int   req;
    exp_t e;
    if (rst) begin
      m_elapsed = 0; m_lvl = 0; m_auto = 0; m_clean = 0;
    end else begin
      enc = enc_of(sw);
      req = mode ? m_auto : enc;
      if (en) begin
        m_elapsed++;
        if (m_elapsed == per_tab[m_lvl]) begin
          e.cyc = cyc + 1;
          e.lvl = req;
          e.hc  = m_clean ? per_tab[m_lvl] / 2 : -1;
          q.push_back(e);
          m_lvl = req; m_elapsed = 0; m_clean = 1;
        end
      end else begin
        m_clean = 0;
      end
      if (!mode || serve) m_auto = enc;
      else if (hit && m_auto < 8) m_auto++;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic m,
                      input logic [7:0] s, input logic h, input logic sv);
    @(negedge clk);
    if (rst_prev) begin
      checks++;
      if (tick !== 1'b0 || clk_ball !== 1'b0 || level !== 4'd0 || at_max !== 1'b0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got tick=%0b clk_ball=%0b level=%0d at_max=%0b want all 0",
                 cyc, tick, clk_ball, level, at_max);
      end
    end
    rst = r; en = e; mode = m; sw = s; hit = h; serve = sv;
    model_step();
    rst_prev = r;
  endtask

  // Monitor: pops the expectation whenever a tick is presented.
  exp_t mon_e;
  int   hc_cnt = 0;
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      mon_e = q.pop_front();
      checks++; failures++;
      $display("FAIL tick_missing at cyc=%0d want tick at cyc=%0d", cyc, mon_e.cyc);
    end
    if (tick === 1'b1) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL tick_unexpected at cyc=%0d level=%0d", cyc, level);
      end else begin
        mon_e = q.pop_front();
        checks++;
        if (mon_e.cyc != cyc) begin
          failures++;
          $display("FAIL tick_cycle got cyc=%0d want cyc=%0d", cyc, mon_e.cyc);
        end
        checks++;
        if (level !== 4'(mon_e.lvl)) begin
          failures++;
          $display("FAIL tick_level cyc=%0d got %0d want %0d", cyc, level, mon_e.lvl);
        end
        checks++;
        if (at_max !== (mon_e.lvl == 8)) begin
          failures++;
          $display("FAIL at_max cyc=%0d got %0b want %0b", cyc, at_max, mon_e.lvl == 8);
        end
        if (mon_e.hc >= 0) begin
          checks++;
          if (hc_cnt != mon_e.hc) begin
            failures++;
            $display("FAIL clk_ball_high cyc=%0d got %0d want %0d", cyc, hc_cnt, mon_e.hc);
          end
        end
        $display("tick cyc=%0d level=%0d at_max=%0b hc=%0d", cyc, level, at_max, hc_cnt);
      end
      hc_cnt = (clk_ball === 1'b1) ? 1 : 0;
    end else begin
      hc_cnt += (clk_ball === 1'b1) ? 1 : 0;
    end
  end

  initial begin
    logic [7:0] s;
    logic       m;
    bit         en_kind;
    int         len;
    rst = 1'b1; en = 1'b0; mode = 1'b0; sw = 8'h00; hit = 1'b0; serve = 1'b0;

    // Reset, then manual level 0 for two full periods
    step(1, 0, 0, 8'h00, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 2300; i++) step(0, 1, 0, 8'h00, 0, 0);
    // Switch request mid-period to the fastest level
    for (int i = 0; i < 1100; i++) step(0, 1, 0, 8'h81, 0, 0);
    // Auto ramp: serve, three hits, then ten hits to saturate
    step(0, 1, 1, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 8'h00, 1, 0);
      step(0, 1, 1, 8'h00, 0, 0);
    end
    for (int i = 0; i < 1200; i++) step(0, 1, 1, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 8'h00, 1, 0);
    for (int i = 0; i < 700; i++) step(0, 1, 1, 8'h00, 0, 0);
    // Hit and serve together: serve wins
    step(0, 1, 1, 8'h02, 1, 1);
    for (int i = 0; i < 1300; i++) step(0, 1, 1, 8'h02, 0, 0);
    // Reset mid-period, then freeze for 200 cycles inside level 0
    step(1, 1, 1, 8'h00, 0, 0);
    for (int i = 0; i < 400; i++) step(0, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 200; i++) step(0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 1500; i++) step(0, 1, 0, 8'h00, 0, 0);

    // Random segments
    for (int seg = 0; seg < 20; seg++) begin
      m       = 1'($urandom % 2);
      en_kind = ($urandom % 3) == 0;
      case ($urandom % 3)
        0:       s = 8'h00;
        1:       s = 8'h01 << ($urandom % 8);
        default: s = 8'($urandom);
      endcase
      len = $urandom_range(300, 1500);
      if (m) step(0, 1, 1, s, 1, 1);
      for (int i = 0; i < len; i++) begin
        if ($urandom % 400 == 0) s = 8'($urandom);
        step(($urandom % 6000) == 0,
             en_kind ? (($urandom % 8) != 0) : 1'b1,
             m, s,
             ($urandom % 150) == 0,
             ($urandom % 1500) == 0);
      end
    end

    // Drain: run clean, then freeze so no new tick is predicted
    for (int i = 0; i < 2100; i++) step(0, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 0, 0);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL ticks_outstanding got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
